// File: rtl/fc_argmax_classifier_pkg.sv
// Shared constants and types for the LeNet5 argmax classifier stage.
//   LENET_NUM_CLASSES : number of class scores per frame
//   FC_OUT_WIDTH      : signed score width produced by the last FC layer
//   CLS_IDX_WIDTH     : class index width
//   FRAME_WIDTH       : frame sequence counter width
//   cls_state_t       : classifier FSM states
package fc_argmax_classifier_pkg;

    localparam int unsigned LENET_NUM_CLASSES = 10;
    localparam int unsigned FC_OUT_WIDTH      = 64;
    localparam int unsigned CLS_IDX_WIDTH     = 4;
    localparam int unsigned FRAME_WIDTH       = 8;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } cls_state_t;

endpackage : fc_argmax_classifier_pkg

// File: rtl/fc_argmax_classifier_if.sv
// Score-in / result-out valid-ready bundle for the argmax classifier.
//   in_valid/in_ready/in_score/in_last : one class score per beat
//   out_valid/out_ready                : result handshake
//   out_class/out_score/out_err        : winning index, its score, frame-length error
//   out_frame                          : frame sequence number
// slave  = classifier side, master = producer/consumer side.
interface fc_argmax_classifier_if
    import fc_argmax_classifier_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = FC_OUT_WIDTH,
    parameter int unsigned IDX_WIDTH = CLS_IDX_WIDTH
);

    logic                        in_valid;
    logic                        in_ready;
    logic signed [OUT_WIDTH-1:0] in_score;
    logic                        in_last;

    logic                        out_valid;
    logic                        out_ready;
    logic [IDX_WIDTH-1:0]        out_class;
    logic signed [OUT_WIDTH-1:0] out_score;
    logic                        out_err;
    logic [FRAME_WIDTH-1:0]      out_frame;

    modport slave (
        input  in_valid, in_score, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score, out_err, out_frame
    );

    modport master (
        output in_valid, in_score, in_last, out_ready,
        input  in_ready, out_valid, out_class, out_score, out_err, out_frame
    );

endinterface : fc_argmax_classifier_if

// File: rtl/fc_argmax_classifier.sv
// Final LeNet5 classifier stage: streams NUM_CLASSES signed scores per frame,
// tracks the running maximum and emits the winning class index, its score and
// a frame-length error flag.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : fc_argmax_classifier_if.slave (score stream in, result out)
// NUM_CLASSES must be >= 2 and IDX_WIDTH >= $clog2(NUM_CLASSES).
module fc_argmax_classifier
    import fc_argmax_classifier_pkg::*;
#(
    parameter int unsigned OUT_WIDTH   = FC_OUT_WIDTH,
    parameter int unsigned NUM_CLASSES = LENET_NUM_CLASSES,
    parameter int unsigned IDX_WIDTH   = CLS_IDX_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst_n,
    fc_argmax_classifier_if.slave bus
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    cls_state_t                  state_q;
    logic [IDX_WIDTH-1:0]        cnt_q;
    logic signed [OUT_WIDTH-1:0] max_q;
    logic [IDX_WIDTH-1:0]        idx_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic [IDX_WIDTH-1:0]        out_class_q;
    logic signed [OUT_WIDTH-1:0] out_score_q;
    logic                        out_err_q;
    logic [FRAME_WIDTH-1:0]      out_frame_q;

    logic                        last_cnt_c;
    logic                        close_c;
    logic                        take_c;
    logic signed [OUT_WIDTH-1:0] max_d;
    logic [IDX_WIDTH-1:0]        idx_d;

    // Running-max update including the current beat; strict '>' keeps the lowest index on ties.
    always_comb begin
        last_cnt_c = (cnt_q == LAST_IDX);
        close_c    = bus.in_last | last_cnt_c;
        take_c     = (cnt_q == '0) || (bus.in_score > max_q);
        max_d      = take_c ? bus.in_score : max_q;
        idx_d      = take_c ? cnt_q : idx_q;
    end

    // FSM and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
            out_err_q   <= 1'b0;
            out_frame_q <= '0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (!in_ready_q) begin
                        // Only reachable on the first cycle after reset release.
                        in_ready_q <= 1'b1;
                    end else if (bus.in_valid) begin
                        max_q <= max_d;
                        idx_q <= idx_d;
                        if (close_c) begin
                            out_class_q <= idx_d;
                            out_score_q <= max_d;
                            // Error when in_last and the final count disagree.
                            out_err_q   <= bus.in_last ^ last_cnt_c;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= S_OUT;
                        end else begin
                            cnt_q <= cnt_q + IDX_WIDTH'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_frame_q <= out_frame_q + FRAME_WIDTH'(1);
                        in_ready_q  <= 1'b1;
                        state_q     <= S_ACC;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_frame = out_frame_q;

endmodule : fc_argmax_classifier

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier: directed table, reset corner
// cases and randomized frames checked against an argmax reference model.
module tb_fc_argmax_classifier;
    import fc_argmax_classifier_pkg::*;

    localparam int NUM = int'(LENET_NUM_CLASSES);
    localparam int W   = int'(FC_OUT_WIDTH);

    typedef logic signed [W-1:0] score_t;
    typedef score_t score_arr_t [NUM];

    typedef struct {
        score_arr_t  sc;
        int          last_pos;   // -1: in_last never asserted
        int          hold;       // cycles of out_ready=0 before the handshake
        logic [3:0]  ecls;
        score_t      escore;
        logic        eerr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fc_argmax_classifier_if bus_if ();

    fc_argmax_classifier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_frame = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat index on which a frame closes: first in_last or the last class slot.
    function automatic int close_idx(input int last_pos);
        return (last_pos >= 0 && last_pos < NUM - 1) ? last_pos : NUM - 1;
    endfunction

    // Reference: first index of the maximum over the received beats.
    task automatic ref_model(input score_arr_t sc, input int last_pos,
                             output logic [3:0] cls, output score_t best, output logic err);
        int n;
        int b;
        n = close_idx(last_pos) + 1;
        b = 0;
        for (int i = 1; i < n; i++)
            if (sc[i] > sc[b]) b = i;
        cls  = 4'(b);
        best = sc[b];
        err  = (last_pos != NUM - 1);
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input score_t s, input logic l);
        int budget;
        budget = 50;
        bus_if.in_valid = 1'b1;
        bus_if.in_score = s;
        bus_if.in_last  = l;
        while (!bus_if.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus_if.in_ready) chk("in_ready_timeout", 64'(bus_if.in_ready), 64'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic reset_and_check();
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  64'(bus_if.in_ready),  64'd0);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_out_class", 64'(bus_if.out_class), 64'd0);
        chk("rst_out_score", 64'(bus_if.out_score), 64'd0);
        chk("rst_out_err",   64'(bus_if.out_err),   64'd0);
        chk("rst_out_frame", 64'(bus_if.out_frame), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_frame = 0;
        #1;
        chk("rel_in_ready_low", 64'(bus_if.in_ready), 64'd0);
        @(negedge clk);
        chk("rel_in_ready_high", 64'(bus_if.in_ready), 64'd1);
    endtask

    task automatic run_frame(input score_arr_t sc, input int last_pos, input int hold,
                             input bit gaps, input logic [3:0] ecls, input score_t escore,
                             input logic eerr);
        int c;
        c = close_idx(last_pos);
        for (int i = 0; i <= c; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(sc[i], logic'(i == last_pos));
        end
        chk("latency_out_valid", 64'(bus_if.out_valid), 64'd1);
        chk("res_in_ready",      64'(bus_if.in_ready),  64'd0);
        chk("res_class",         64'(bus_if.out_class), 64'(ecls));
        chk("res_score",         64'(bus_if.out_score), 64'(escore));
        chk("res_err",           64'(bus_if.out_err),   64'(eerr));
        chk("res_frame",         64'(bus_if.out_frame), 64'(exp_frame));
        for (int h = 0; h < hold; h++) begin
            // Beats offered while the result is pending must be ignored.
            bus_if.in_valid = 1'b1;
            bus_if.in_score = score_t'({$urandom, $urandom});
            bus_if.in_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_out_valid", 64'(bus_if.out_valid), 64'd1);
            chk("hold_in_ready",  64'(bus_if.in_ready),  64'd0);
            chk("hold_class",     64'(bus_if.out_class), 64'(ecls));
            chk("hold_score",     64'(bus_if.out_score), 64'(escore));
        end
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        exp_frame = (exp_frame + 1) % 256;
        chk("hs_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("hs_in_ready",  64'(bus_if.in_ready),  64'd1);
        chk("hs_frame",     64'(bus_if.out_frame), 64'(exp_frame));
    endtask

    task automatic add_vec(input score_arr_t sc, input int lp, input int hold,
                           input logic [3:0] c, input score_t s, input logic e);
        vec_t v;
        v.sc = sc; v.last_pos = lp; v.hold = hold;
        v.ecls = c; v.escore = s; v.eerr = e;
        vq.push_back(v);
    endtask

    function automatic score_t rnd_score();
        int v;
        case ($urandom_range(0, 2))
            0: return score_t'({$urandom, $urandom});
            1: begin v = int'($urandom_range(0, 6)) - 3;   return score_t'(v); end
            default: begin v = int'($urandom_range(0, 999)) - 500; return score_t'(v); end
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 5000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        score_arr_t t;
        score_arr_t r;
        logic [3:0] mc;
        score_t     ms;
        logic       me;
        int         lp;

        bus_if.in_valid  = 1'b0;
        bus_if.in_score  = '0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;
        #2;
        reset_and_check();

        t = '{3, -8, 20, 7, 0, 1, 9, 500, -2, 499};
        add_vec(t, 9, 0, 4'd7, 500, 1'b0);
        t = '{-100, -100, -100, -1, -100, -100, -100, -100, -100, -100};
        add_vec(t, 9, 5, 4'd3, -1, 1'b0);
        t = '{1, 2, 42, 3, 4, 42, 0, -5, 41, 10};
        add_vec(t, 9, 0, 4'd2, 42, 1'b0);
        t = '{5, 9, -3, 9, 2, 8, 100, 100, 100, 100};
        add_vec(t, 5, 0, 4'd1, 9, 1'b1);
        t = '{-7, -3, -3, -9, -1, -2, -8, -1, -5, -4};
        add_vec(t, -1, 0, 4'd4, -1, 1'b1);
        t = '{64'sh8000_0000_0000_0000, -1, 0, 1, 2, 3,
              64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF, 0, 64'sh8000_0000_0000_0000};
        add_vec(t, 9, 2, 4'd6, 64'sh7FFF_FFFF_FFFF_FFFF, 1'b0);
        t = '{-50, 70, 80, 90, 1, 1, 1, 1, 1, 1};
        add_vec(t, 0, 0, 4'd0, -50, 1'b1);
        t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        add_vec(t, 9, 0, 4'd9, 1, 1'b0);

        foreach (vq[k])
            run_frame(vq[k].sc, vq[k].last_pos, vq[k].hold, 1'b0,
                      vq[k].ecls, vq[k].escore, vq[k].eerr);

        // Reset after 4 beats of a frame: partial frame discarded.
        for (int i = 0; i < 4; i++) send_beat(score_t'(1000 + i), 1'b0);
        reset_and_check();
        run_frame(vq[0].sc, vq[0].last_pos, 0, 1'b0, vq[0].ecls, vq[0].escore, vq[0].eerr);

        // Random frames; together with the frame above this makes 256 since reset.
        for (int f = 0; f < 255; f++) begin
            foreach (r[i]) r[i] = rnd_score();
            lp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) - 1 : NUM - 1;
            ref_model(r, lp, mc, ms, me);
            run_frame(r, lp, int'($urandom_range(0, 2)), 1'b1, mc, ms, me);
        end
        chk("frame_wrap", 64'(bus_if.out_frame), 64'd0);

        // Reset while a result is pending: result dropped.
        for (int i = 0; i < NUM; i++) send_beat(vq[0].sc[i], logic'(i == NUM - 1));
        chk("pending_out_valid", 64'(bus_if.out_valid), 64'd1);
        reset_and_check();
        run_frame(vq[2].sc, vq[2].last_pos, 1, 1'b0, vq[2].ecls, vq[2].escore, vq[2].eerr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fc_argmax_classifier
